// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed combinationally from latched operands and committed after a fixed delay.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  MDUop,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              issue, issue_md, finish;
  logic [63:0]       a_ext, b_ext, prod;
  logic              a_neg, b_neg;
  logic [31:0]       a_mag, b_mag, quo_mag, rem_mag, quo, rem;

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Sign-extending both operands makes one 64-bit multiplier serve mult and multu.
  assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  assign a_neg   = sgn_q & a_q[31];
  assign b_neg   = sgn_q & b_q[31];
  assign a_mag   = a_neg ? -a_q : a_q;
  assign b_mag   = b_neg ? -b_q : b_q;
  assign quo_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign rem_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign quo     = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
  assign rem     = a_neg ? -rem_mag : rem_mag;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (MDUop)
            3'd0, 3'd1: begin
              state_d = StMul;
              cnt_d   = CntW'(MULT_CYCLES);
            end
            3'd2, 3'd3: begin
              state_d = StDiv;
              cnt_d   = CntW'(DIV_CYCLES);
            end
            default: ;
          endcase
        end
      end
      StMul, StDiv: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output / datapath logic
  always_comb begin
    issue    = (state_q == StIdle) && start;
    issue_md = issue && (MDUop <= 3'd3);
    finish   = (state_q != StIdle) && (cnt_q <= CntW'(1));

    a_d    = a_q;
    b_d    = b_q;
    sgn_d  = sgn_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    busy_d = (state_d != StIdle);

    if (issue_md) begin
      a_d   = rs;
      b_d   = rt;
      sgn_d = ~MDUop[0];
    end
    if (issue && (MDUop == 3'd4)) hi_d = rs;
    if (issue && (MDUop == 3'd5)) lo_d = rs;

    if (finish) begin
      done_d = 1'b1;
      if (state_q == StMul) begin
        hi_d = prod[63:32];
        lo_d = prod[31:0];
      end else if (b_q != '0) begin
        // A zero divisor still burns the full busy period but leaves HI/LO intact.
        hi_d = rem;
        lo_d = quo;
      end
    end
  end

endmodule
